// File: rtl/branch_pkg.sv
// Shared constants and result flag type for the branch resolve unit.
package branch_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef struct packed {
      logic taken;
      logic mispredict;
      logic illegal;
   } br_flags_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of the six conditional-branch predicates.
module branch_cond_eval
   import branch_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [2:0]      funct3,
   output logic            taken,
   output logic            illegal
);

   logic eq;
   logic lt;
   logic ltu;

   assign eq  = (rs1 == rs2);
   assign lt  = ($signed(rs1) < $signed(rs2));
   assign ltu = (rs1 < rs2);

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (funct3)
         F3_BEQ:  taken = eq;
         F3_BNE:  taken = !eq;
         F3_BLT:  taken = lt;
         F3_BGE:  taken = !lt;
         F3_BLTU: taken = ltu;
         F3_BGEU: taken = !ltu;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution with valid/ready handshake and flush.
// Optional statistics counters are enabled by defining BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int CNT_W = 16
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_imm,
   input  logic            in_pred_taken,
   input  logic            flush,
`ifdef BRANCH_RESOLVE_STATS_EN
   input  logic             stat_clear,
   output logic [CNT_W-1:0] stat_branches,
   output logic [CNT_W-1:0] stat_mispred,
`endif
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_taken,
   output logic [XLEN-1:0] out_redirect_pc,
   output logic            out_mispredict,
   output logic            out_illegal
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("branch_resolve_unit: XLEN must be 32 or 64");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("branch_resolve_unit: CNT_W must be at least 1");
   end

   logic            cond_taken;
   logic            cond_illegal;
   logic [XLEN-1:0] target_pc;
   logic [XLEN-1:0] fall_pc;
   logic            accept;
   br_flags_t       flags_d;
   br_flags_t       flags_q;
   logic [XLEN-1:0] redirect_q;
   logic            valid_q;

   branch_cond_eval #(.XLEN(XLEN)) u_cond (
      .rs1     (in_rs1),
      .rs2     (in_rs2),
      .funct3  (in_funct3),
      .taken   (cond_taken),
      .illegal (cond_illegal)
   );

   // Both adders wrap naturally at XLEN bits.
   assign target_pc = in_pc + in_imm;
   assign fall_pc   = in_pc + XLEN'(4);

   // Illegal encodings force not-taken, so mispredict reduces to pred_taken.
   assign flags_d.taken      = cond_taken;
   assign flags_d.illegal    = cond_illegal;
   assign flags_d.mispredict = cond_taken ^ in_pred_taken;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q    <= 1'b0;
         flags_q    <= '0;
         redirect_q <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q    <= 1'b1;
         flags_q    <= flags_d;
         redirect_q <= cond_taken ? target_pc : fall_pc;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid       = valid_q;
   assign out_taken       = flags_q.taken;
   assign out_mispredict  = flags_q.mispredict;
   assign out_illegal     = flags_q.illegal;
   assign out_redirect_pc = redirect_q;

`ifdef BRANCH_RESOLVE_STATS_EN
   logic             handshake;
   logic [CNT_W-1:0] br_cnt_q;
   logic [CNT_W-1:0] mp_cnt_q;

   assign handshake = valid_q && out_ready && !flush;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         br_cnt_q <= '0;
         mp_cnt_q <= '0;
      end else if (stat_clear) begin
         br_cnt_q <= '0;
         mp_cnt_q <= '0;
      end else if (handshake) begin
         if (br_cnt_q != '1)
            br_cnt_q <= br_cnt_q + CNT_W'(1);
         if (flags_q.mispredict && mp_cnt_q != '1)
            mp_cnt_q <= mp_cnt_q + CNT_W'(1);
      end
   end

   assign stat_branches = br_cnt_q;
   assign stat_mispred  = mp_cnt_q;
`endif

endmodule
